fmul_unit: RTL and testbench

Pipelined IEEE-754 single-precision floating-point multiplier for the FPU datapath. Computes y = x1 × x2 with round-to-nearest-even, subnormals flushed to zero, and overflow to signed infinity. Fully pipelined: it accepts a new operand pair every cycle with fixed latency, and has no handshake.

---
 rtl/fmul_unit.sv | 87 ++++++++
 tb/tb_fmul_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fmul_unit.sv
// fmul_unit: two-stage pipelined binary32 multiplier (RNE, FTZ); define FMUL_SPECIAL_EN for inf/NaN handling
module fmul_unit (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  input  logic        clk,
  input  logic        rstn
);
  logic               sign_d, sign_q, zero_d, zero_q;
  logic signed [9:0]  exp_d, exp_q;
  logic [35:0]        lo_d, lo_q, hi_d, hi_q;
  logic [23:0]        ma, mb;
  logic [47:0]        prod;
  logic               norm, guard, sticky;
  logic [22:0]        mant;
  logic [23:0]        rnd;
  logic signed [9:0]  exp_f;
  logic [31:0]        y_d, y_q, y_norm;
`ifdef FMUL_SPECIAL_EN
  logic               nan_d, nan_q, inf_d, inf_q;
  logic               inf1, inf2, nan1, nan2;
`endif
  // stage 1: sign, exponent sum, zero flag and two 24x12 partial products
  always_comb begin
    ma = {1'b1, x1[22:0]};
    mb = {1'b1, x2[22:0]};
    sign_d = x1[31] ^ x2[31];
    zero_d = (x1[30:23] == 8'd0) || (x2[30:23] == 8'd0);
    exp_d = $signed({2'b0, x1[30:23]}) + $signed({2'b0, x2[30:23]}) - 10'sd127;
    lo_d = 36'(ma) * 36'(mb[11:0]);
    hi_d = 36'(ma) * 36'(mb[23:12]);
`ifdef FMUL_SPECIAL_EN
    inf1 = (x1[30:23] == 8'hff) && (x1[22:0] == 23'd0);
    inf2 = (x2[30:23] == 8'hff) && (x2[22:0] == 23'd0);
    nan1 = (x1[30:23] == 8'hff) && (x1[22:0] != 23'd0);
    nan2 = (x2[30:23] == 8'hff) && (x2[22:0] != 23'd0);
    nan_d = nan1 || nan2 || (inf1 && x2[30:23] == 8'd0) || (inf2 && x1[30:23] == 8'd0);
    inf_d = inf1 || inf2;
`endif
  end
  // stage 2: sum partials, normalize, round to nearest even, saturate/flush and pack
  always_comb begin
    prod = {12'd0, lo_q} + {hi_q, 12'd0};
    norm = prod[47];
    mant = norm ? prod[46:24] : prod[45:23];
    guard = norm ? prod[23] : prod[22];
    sticky = norm ? |prod[22:0] : |prod[21:0];
    rnd = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
    exp_f = exp_q + {9'd0, norm} + {9'd0, rnd[23]};
    y_norm = zero_q ? {sign_q, 31'd0} :
             (exp_f >= 10'sd255) ? {sign_q, 8'hff, 23'd0} :
             (exp_f <= 10'sd0) ? {sign_q, 31'd0} :
             {sign_q, exp_f[7:0], rnd[22:0]};
`ifdef FMUL_SPECIAL_EN
    y_d = nan_q ? 32'h7fc00000 : inf_q ? {sign_q, 8'hff, 23'd0} : y_norm;
`else
    y_d = y_norm;
`endif
  end
  // pipeline registers, cleared asynchronously so in-flight results are dropped
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      exp_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      y_q    <= '0;
`ifdef FMUL_SPECIAL_EN
      nan_q  <= 1'b0;
      inf_q  <= 1'b0;
`endif
    end else begin
      sign_q <= sign_d;
      zero_q <= zero_d;
      exp_q  <= exp_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      y_q    <= y_d;
`ifdef FMUL_SPECIAL_EN
      nan_q  <= nan_d;
      inf_q  <= inf_d;
`endif
    end
  end
  assign y = y_q;
endmodule

// File: tb/tb_fmul_unit.sv
// tb_fmul_unit: scoreboard bench for fmul_unit, expected values from a double-precision reference
module tb_fmul_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] x1, x2, y;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [31:0] v;
    bit          chk;
    string       tag;
  } exp_t;
  exp_t q[$];

  fmul_unit dut (.x1(x1), .x2(x2), .y(y), .clk(clk), .rstn(rstn));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference: exact product in double, then rounded to binary32 with RNE
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit c);
    logic        s;
    logic [63:0] pb;
    real         ra, rb;
    int          se;
    logic [23:0] m;
    logic        g, st;
    s = a[31] ^ b[31];
    c = 1'b1;
    r = {s, 31'd0};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return;
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) begin
      c = 1'b0;
      return;
    end
    ra = $bitstoreal({1'b0, {3'd0, a[30:23]} + 11'd896, a[22:0], 29'd0});
    rb = $bitstoreal({1'b0, {3'd0, b[30:23]} + 11'd896, b[22:0], 29'd0});
    pb = $realtobits(ra * rb);
    se = int'(pb[62:52]) - 896;
    if (se <= 0) begin
      c = 1'b0;
      return;
    end
    g = pb[28];
    st = |pb[27:0];
    m = {1'b0, pb[51:29]} + {23'd0, g & (st | pb[29])};
    if (m[23]) se++;
    r = (se >= 255) ? {s, 8'hff, 23'd0} : {s, se[7:0], m[22:0]};
  endfunction

  task automatic step(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input bit c, input string tag);
    exp_t t;
    x1 = a;
    x2 = b;
    q.push_back('{e, c, tag});
    @(posedge clk);
    #1;
    t = q.pop_front();
    if (t.chk) check(t.tag, y, t.v);
  endtask

  task automatic rstep(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] e;
    bit          c;
    model(a, b, e, c);
    step(a, b, e, c, "rand");
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    int         k;
    k = $urandom_range(0, 15);
    e = (k == 0) ? 8'd0 : (k == 1) ? 8'($urandom_range(1, 254)) : 8'($urandom_range(60, 194));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    rstn = 1'b1;
    x1 = 'x;
    x2 = 'x;
    repeat (3) @(posedge clk);
    #1;
    check("reset_y", y, 32'h0);
    rstn = 1'b0;
    q.push_back('{32'h0, 1'b1, "post_reset"});
    step(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b1, "one_x_one");
    step(32'h40000000, 32'hC0400000, 32'hC0C00000, 1'b1, "two_x_neg3");
    step(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b1, "1p5_sq");
    step(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b1, "round");
    step(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, "overflow");
    step(32'h00800000, 32'h00800000, 32'h00000000, 1'b1, "underflow");
    step(32'h80000000, 32'h3F800000, 32'h80000000, 1'b1, "neg_zero");
    step(32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b1, "neg_one");
    step(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b1, "near_two_sq");
    step(32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 1'b1, "round_ovf");
    step(32'h00FFFFFF, 32'h3F000000, 32'h00000000, 1'b1, "ftz_result");
`ifdef FMUL_SPECIAL_EN
    step(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, "inf_x_zero");
    step(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b1, "nan_in");
    step(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1, "ninf_x_two");
    step(32'h7F800000, 32'hFF800000, 32'hFF800000, 1'b1, "inf_x_ninf");
`endif
    step(32'h40400000, 32'h40400000, 32'h41100000, 1'b1, "three_sq");
    #3;
    rstn = 1'b1;
    #1;
    check("async_reset", y, 32'h0);
    q.delete();
    q.push_back('{32'h0, 1'b1, "in_flight_drop"});
    @(posedge clk);
    #1;
    rstn = 1'b0;
    for (int i = 0; i < 255; i++) rstep(rand_op(), rand_op());
    step(32'h0, 32'h0, 32'h0, 1'b1, "flush");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
